// File: rtl/memory_slave_bridge_pkg.sv
// memory_bridge_pkg: shared command codes, FSM states and status bit positions for the bridge
package memory_bridge_pkg;
    localparam int FIELD_WIDTH = 24;
    typedef enum logic [7:0] {
        CMD_NONE           = 8'd0,
        CMD_DATA_LO        = 8'd1,
        CMD_DATA_HI        = 8'd2,
        CMD_MASTER_ID      = 8'd3,
        CMD_TRY_SEND       = 8'd4,
        CMD_READ_ADDRESS   = 8'd5,
        CMD_READ_DATA_LO   = 8'd6,
        CMD_READ_DATA_HI   = 8'd7,
        CMD_READ_MASTER_ID = 8'd8,
        CMD_READ_WRITE     = 8'd9,
        CMD_POP            = 8'd10,
        CMD_READ_STATUS    = 8'd11,
        CMD_CLEAR_ERROR    = 8'd12
    } cmd_e;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam int STAT_COUNT_LSB = 24;
    localparam int STAT_WAIT      = 4;
    localparam int STAT_EMPTY     = 3;
    localparam int STAT_FULL      = 2;
    localparam int STAT_TIMEOUT   = 1;
    localparam int STAT_UNDERFLOW = 0;
endpackage

// File: rtl/memory_slave_bridge_if.sv
// memory_slave_bridge_if: master request / slave response signals of one memory bus slave port
interface memory_slave_bridge_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 48,
    parameter int ID_WIDTH   = 8
);
    logic                  msValid;
    logic [ADDR_WIDTH-1:0] msAddress;
    logic [DATA_WIDTH-1:0] msData;
    logic [ID_WIDTH-1:0]   msID;
    logic                  msWrite;
    logic                  msTake;
    logic                  smValid;
    logic [DATA_WIDTH-1:0] smData;
    logic [ID_WIDTH-1:0]   smID;
    logic                  smTaken;
    modport master (
        output msValid, msAddress, msData, msID, msWrite, smTaken,
        input  msTake, smValid, smData, smID
    );
    modport slave (
        input  msValid, msAddress, msData, msID, msWrite, smTaken,
        output msTake, smValid, smData, smID
    );
endinterface

// File: rtl/memory_slave_bridge_request_fifo.sv
// request_fifo: synchronous FIFO holding accepted master requests, with occupancy flags
module request_fifo #(
    parameter int WIDTH = 89,
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;
    assign full    = count == CW'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = mem[rd_ptr];
    // pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end
    // storage needs no reset; stale slots are never visible past the count
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end
endmodule

// File: rtl/memory_slave_bridge.sv
// memory_slave_bridge: software-driven memory bus slave behind a 32-bit command/response word
module memory_slave_bridge
    import memory_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 48,
    parameter int ID_WIDTH   = 8,
    parameter int REQ_DEPTH  = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [31:0]           in,
    output logic [31:0]           out,
    memory_slave_bridge_if.slave  bus
);
    localparam int EW   = ADDR_WIDTH + DATA_WIDTH + ID_WIDTH + 1;
    localparam int CNTW = $clog2(REQ_DEPTH+1);
    localparam int TW   = TIMEOUT > 0 ? $clog2(TIMEOUT+1) : 1;
    localparam logic [TW-1:0]         TLAST   = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
    localparam logic [DATA_WIDTH-1:0] LO_MASK = DATA_WIDTH'(24'hFFFFFF);
    logic [7:0]             cmd;
    logic [FIELD_WIDTH-1:0] field;
    logic [1:0]             state;
    logic [TW-1:0]          wcnt;
    logic                   err_to;
    logic                   err_uf;
    logic [DATA_WIDTH-1:0]  data_q;
    logic [ID_WIDTH-1:0]    id_q;
    logic [EW-1:0]          head;
    logic [CNTW-1:0]        count;
    logic                   full;
    logic                   empty;
    logic                   fifo_pop;
    logic                   timeout_hit;
    logic [ADDR_WIDTH-1:0]  head_addr;
    logic [DATA_WIDTH-1:0]  head_data;
    logic [ID_WIDTH-1:0]    head_id;
    logic                   head_write;
    assign cmd   = in[31:24];
    assign field = in[23:0];
    assign {head_addr, head_data, head_id, head_write} = head;
    assign bus.msTake  = !full && !reset;
    assign bus.smValid = state == ST_SEND;
    assign bus.smData  = data_q;
    assign bus.smID    = id_q;
    assign fifo_pop    = state == ST_IDLE && cmd == CMD_POP && !empty;
    assign timeout_hit = TIMEOUT != 0 && wcnt == TLAST;
    request_fifo #(.WIDTH(EW), .DEPTH(REQ_DEPTH)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (bus.msValid && bus.msTake),
        .pop   (fifo_pop),
        .wdata ({bus.msAddress, bus.msData, bus.msID, bus.msWrite}),
        .rdata (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );
    // command sequencer: actions fire in IDLE, WAIT holds until software issues NONE
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= ST_IDLE;
            wcnt   <= '0;
            err_to <= 1'b0;
            err_uf <= 1'b0;
            data_q <= '0;
            id_q   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wcnt <= '0;
                    case (cmd)
                        CMD_DATA_LO:   data_q <= (data_q & ~LO_MASK) | DATA_WIDTH'(field);
                        CMD_DATA_HI:   data_q <= (data_q & LO_MASK) | DATA_WIDTH'({field, 24'b0});
                        CMD_MASTER_ID: id_q <= field[ID_WIDTH-1:0];
                        CMD_TRY_SEND:  state <= ST_SEND;
                        CMD_POP: begin
                            state <= ST_WAIT;
                            if (empty) err_uf <= 1'b1;
                        end
                        CMD_CLEAR_ERROR: begin
                            state  <= ST_WAIT;
                            err_to <= 1'b0;
                            err_uf <= 1'b0;
                        end
                        default: ;
                    endcase
                end
                ST_SEND: begin
                    if (bus.smTaken) state <= ST_WAIT;
                    else if (timeout_hit) begin
                        state  <= ST_WAIT;
                        err_to <= 1'b1;
                    end else wcnt <= wcnt + TW'(1);
                end
                default: if (cmd == CMD_NONE) state <= ST_IDLE;
            endcase
        end
    end
    // response word: FIFO head fields, status, or handshake progress depending on command
    always_comb begin
        out = '0;
        case (cmd)
            CMD_READ_ADDRESS:   out = empty ? '0 : 32'(head_addr);
            CMD_READ_DATA_LO:   out = empty ? '0 : 32'(24'(head_data));
            CMD_READ_DATA_HI:   out = empty ? '0 : 32'(24'(head_data >> FIELD_WIDTH));
            CMD_READ_MASTER_ID: out = empty ? '0 : 32'(head_id);
            CMD_READ_WRITE:     out = empty ? '0 : 32'(head_write);
            CMD_READ_STATUS:    out = {8'(count), 19'b0, state == ST_WAIT, empty, full, err_to, err_uf};
            CMD_TRY_SEND, CMD_POP, CMD_CLEAR_ERROR: out = {30'b0, err_to | err_uf, state == ST_WAIT};
            default:            out = '0;
        endcase
    end
endmodule

// File: tb/tb_memory_slave_bridge.sv
// tb_memory_slave_bridge: directed self-checking bench for the memory slave bridge
module tb_memory_slave_bridge;
    localparam int AW = 32;
    localparam int DW = 48;
    localparam int IW = 8;
    localparam int DEPTH = 4;
    localparam int TO = 8;
    localparam logic [7:0] C_NONE = 8'd0, C_DATA_LO = 8'd1, C_DATA_HI = 8'd2, C_MASTER_ID = 8'd3;
    localparam logic [7:0] C_TRY_SEND = 8'd4, C_READ_ADDRESS = 8'd5, C_READ_DATA_LO = 8'd6;
    localparam logic [7:0] C_READ_DATA_HI = 8'd7, C_READ_MASTER_ID = 8'd8, C_READ_WRITE = 8'd9;
    localparam logic [7:0] C_POP = 8'd10, C_READ_STATUS = 8'd11, C_CLEAR_ERROR = 8'd12;
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] in_w;
    logic [31:0] out_w;
    int          n_checks = 0;
    int          n_fail = 0;
    int          n;
    memory_slave_bridge_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus();
    memory_slave_bridge #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .REQ_DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in    (in_w),
        .out   (out_w),
        .bus   (bus)
    );
    always #5 clock = ~clock;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask
    task automatic tick;
        @(posedge clock);
        #1;
    endtask
    task automatic do_cmd(input logic [7:0] c, input logic [23:0] f);
        in_w = {c, f};
        tick;
        in_w = {C_NONE, 24'h0};
        tick;
    endtask
    task automatic read_chk(input string tag, input logic [7:0] c, input logic [31:0] exp);
        in_w = {c, 24'h0};
        #1;
        check(tag, out_w, exp);
    endtask
    initial begin
        in_w = '0;
        bus.msValid = 1'b0;
        bus.msAddress = '0;
        bus.msData = '0;
        bus.msID = '0;
        bus.msWrite = 1'b0;
        bus.smTaken = 1'b0;
        repeat (2) tick;
        check("rst_take", bus.msTake, 0);
        check("rst_valid", bus.smValid, 0);
        check("rst_data", bus.smData, 0);
        check("rst_id", bus.smID, 0);
        reset = 1'b0;
        #1;
        check("take_after_rst", bus.msTake, 1);
        read_chk("rst_status", C_READ_STATUS, 32'h0000_0008);
        in_w = '0;
        tick;
        // three requests, then inspect and pop the head
        for (int i = 0; i < 3; i++) begin
            bus.msAddress = 32'h10 * (i + 1);
            bus.msData = 48'h100 + 48'(i);
            bus.msID = 8'(i + 7);
            bus.msWrite = (i != 1);
            bus.msValid = 1'b1;
            tick;
        end
        bus.msValid = 1'b0;
        read_chk("count3", C_READ_STATUS, 32'h0300_0000);
        read_chk("addr_head", C_READ_ADDRESS, 32'h10);
        read_chk("write_head", C_READ_WRITE, 32'h1);
        read_chk("data_lo_head", C_READ_DATA_LO, 32'h100);
        read_chk("data_hi_head", C_READ_DATA_HI, 32'h0);
        read_chk("id_head", C_READ_MASTER_ID, 32'h7);
        read_chk("pop_ret_idle", C_POP, 32'h0);
        tick;
        check("pop_ret_wait", out_w, 32'h1);
        in_w = '0;
        tick;
        read_chk("addr_after_pop", C_READ_ADDRESS, 32'h20);
        read_chk("write_after_pop", C_READ_WRITE, 32'h0);
        do_cmd(C_POP, 24'h0);
        do_cmd(C_POP, 24'h0);
        read_chk("drained", C_READ_STATUS, 32'h0000_0008);
        // overfill: fifth request is refused until a POP frees a slot
        for (int i = 0; i < 5; i++) begin
            bus.msAddress = 32'h100 + 32'(i);
            bus.msValid = 1'b1;
            #1;
            check($sformatf("take%0d", i), bus.msTake, (i < 4) ? 1 : 0);
            tick;
        end
        read_chk("full_status", C_READ_STATUS, 32'h0400_0004);
        in_w = {C_POP, 24'h0};
        #1;
        check("take_full_pop", bus.msTake, 0);
        tick;
        check("take_after_pop", bus.msTake, 1);
        tick;
        bus.msValid = 1'b0;
        in_w = '0;
        tick;
        read_chk("refill_status", C_READ_STATUS, 32'h0400_0004);
        read_chk("refill_head", C_READ_ADDRESS, 32'h101);
        repeat (3) do_cmd(C_POP, 24'h0);
        read_chk("fifth_head", C_READ_ADDRESS, 32'h104);
        do_cmd(C_POP, 24'h0);
        read_chk("empty_read", C_READ_ADDRESS, 32'h0);
        // response assembly and a send taken on the third cycle
        do_cmd(C_DATA_LO, 24'hABCDEF);
        do_cmd(C_DATA_HI, 24'h123456);
        do_cmd(C_MASTER_ID, 24'h5);
        check("sm_data", bus.smData, 48'h1234_56AB_CDEF);
        check("sm_id", bus.smID, 5);
        check("idle_valid", bus.smValid, 0);
        in_w = {C_TRY_SEND, 24'h0};
        tick;
        for (int k = 1; k <= 3; k++) begin
            check($sformatf("send_valid%0d", k), bus.smValid, 1);
            if (k == 3) bus.smTaken = 1'b1;
            tick;
        end
        bus.smTaken = 1'b0;
        check("send_done_valid", bus.smValid, 0);
        check("try_ret_wait", out_w, 32'h1);
        tick;
        check("no_resend", bus.smValid, 0);
        in_w = '0;
        tick;
        read_chk("send_status", C_READ_STATUS, 32'h0000_0008);
        // timeout: no take at all
        in_w = {C_TRY_SEND, 24'h0};
        tick;
        n = 0;
        for (int k = 0; k < 20 && bus.smValid; k++) begin
            n++;
            tick;
        end
        check("timeout_cycles", n, TO);
        read_chk("timeout_status", C_READ_STATUS, 32'h0000_001A);
        in_w = '0;
        tick;
        do_cmd(C_CLEAR_ERROR, 24'h0);
        read_chk("cleared_status", C_READ_STATUS, 32'h0000_0008);
        // take arrives in the timeout cycle: no error
        in_w = {C_TRY_SEND, 24'h0};
        tick;
        for (int k = 1; k <= TO; k++) begin
            if (k == TO) bus.smTaken = 1'b1;
            tick;
        end
        bus.smTaken = 1'b0;
        check("late_take_valid", bus.smValid, 0);
        read_chk("late_take_status", C_READ_STATUS, 32'h0000_0018);
        in_w = '0;
        tick;
        // underflow and single send on a held TRY_SEND
        in_w = {C_POP, 24'h0};
        tick;
        check("uf_ret", out_w, 32'h3);
        in_w = '0;
        tick;
        read_chk("uf_status", C_READ_STATUS, 32'h0000_0009);
        bus.smTaken = 1'b1;
        in_w = {C_TRY_SEND, 24'h0};
        n = 0;
        repeat (20) begin
            tick;
            if (bus.smValid) n++;
        end
        check("held_single_send", n, 1);
        bus.smTaken = 1'b0;
        in_w = '0;
        tick;
        do_cmd(C_CLEAR_ERROR, 24'h0);
        // reset in the middle of a send with two queued requests
        bus.msValid = 1'b1;
        repeat (2) tick;
        bus.msValid = 1'b0;
        read_chk("pre_rst_count", C_READ_STATUS, 32'h0200_0000);
        in_w = {C_TRY_SEND, 24'h0};
        repeat (2) tick;
        check("mid_send_valid", bus.smValid, 1);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_valid", bus.smValid, 0);
        check("async_rst_take", bus.msTake, 0);
        in_w = '0;
        repeat (2) tick;
        reset = 1'b0;
        #1;
        check("post_rst_take", bus.msTake, 1);
        check("post_rst_data", bus.smData, 0);
        read_chk("post_rst_status", C_READ_STATUS, 32'h0000_0008);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
